pc_sequencer: RTL and testbench

//  Owns and sequences the 32-bit program counter of the single-cycle CPU.
//  - Computes next-PC: sequential (+4) or PC-relative branch/jump.
//  - Stalls on instruction-memory busy.
//  - Faults on a stuck memory; optionally halts/resumes.
//  - Sits between the control unit (branch/jump/zero/offset) and instruction memory (pc, imem_req, imem_busy).

---
 rtl/pc_seq_pkg.sv | 16 +
 rtl/pc_next_calc.sv | 27 ++
 rtl/pc_sequencer.sv | 111 +++++++++++
 tb/tb_pc_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
// State encoding plus the sequential PC increment and word-to-byte shift.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_RUN    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_FAULT  = 3'd3,
        ST_HALTED = 3'd4
    } pc_state_e;

    localparam int PC_INC     = 4;
    localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC: pc+4, or pc+4+(sext(offset)<<2) on jump / taken branch.
// Zero latency, no state, no backpressure; arithmetic wraps modulo 2^PC_W.
module pc_next_calc
    import pc_seq_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int OFF_W = 8
) (
    input  logic [PC_W-1:0]  pc,
    input  logic             jump,
    input  logic             branch,
    input  logic             zero,
    input  logic [OFF_W-1:0] offset,
    output logic [PC_W-1:0]  pc_next
);

    logic            take;
    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] off_ext;

    // Jump and taken branch share the same PC-relative target, so priority is moot.
    assign take    = jump | (branch & zero);
    assign seq_pc  = pc + PC_W'(PC_INC);
    assign off_ext = {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};
    assign pc_next = take ? (seq_pc + (off_ext << WORD_SHIFT)) : seq_pc;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter FSM: one instruction per cycle, holds PC while imem_busy, faults after MAX_WAIT.
// Optional HALTED state with halt/resume/halted ports when PC_SEQ_HALT_EN is defined.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter int              OFF_W    = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             imem_busy,
    input  logic             jump,
    input  logic             branch,
    input  logic             zero,
    input  logic [OFF_W-1:0] offset,
`ifdef PC_SEQ_HALT_EN
    input  logic             halt,
    input  logic             resume,
    output logic             halted,
`endif
    output logic [PC_W-1:0]  pc,
    output logic [PC_W-1:0]  pc_next,
    output logic             imem_req,
    output logic             fault
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    pc_state_e       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      wait_cnt_q, wait_cnt_d;
    logic [PC_W-1:0] pc_next_w;

    pc_next_calc #(
        .PC_W  (PC_W),
        .OFF_W (OFF_W)
    ) u_pc_next_calc (
        .pc      (pc_q),
        .jump    (jump),
        .branch  (branch),
        .zero    (zero),
        .offset  (offset),
        .pc_next (pc_next_w)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_RST: state_d = ST_RUN;
            ST_RUN, ST_WAIT: begin
                if (!imem_busy) begin
                    // Acceptance: control inputs are only meaningful on this cycle.
                    wait_cnt_d = 8'd0;
`ifdef PC_SEQ_HALT_EN
                    if (halt) begin
                        state_d = ST_HALTED;
                    end else begin
                        pc_d    = pc_next_w;
                        state_d = ST_RUN;
                    end
`else
                    pc_d    = pc_next_w;
                    state_d = ST_RUN;
`endif
                end else if (state_q == ST_RUN) begin
                    wait_cnt_d = 8'd1;
                    state_d    = ST_WAIT;
                end else if (wait_cnt_q == MAX_WAIT_C) begin
                    state_d = ST_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ST_FAULT: state_d = ST_FAULT;
`ifdef PC_SEQ_HALT_EN
            ST_HALTED: begin
                if (resume) begin
                    pc_d    = pc_q + PC_W'(PC_INC);
                    state_d = ST_RUN;
                end
            end
`endif
            default: state_d = ST_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RST;
            pc_q       <= RESET_PC;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign pc       = pc_q;
    assign pc_next  = pc_next_w;
    assign imem_req = (state_q == ST_RUN) || (state_q == ST_WAIT);
    assign fault    = (state_q == ST_FAULT);
`ifdef PC_SEQ_HALT_EN
    assign halted   = (state_q == ST_HALTED);
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: vector table for next-PC/stall behaviour plus
// hand sequences for the wait limit, fault, reset-mid-WAIT and optional halt.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_busy = 1'b0;
    logic        jump = 1'b0;
    logic        branch = 1'b0;
    logic        zero = 1'b0;
    logic [7:0]  offset = 8'h00;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        imem_req;
    logic        fault;
`ifdef PC_SEQ_HALT_EN
    logic        halt = 1'b0;
    logic        resume = 1'b0;
    logic        halted;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .PC_W     (32),
        .OFF_W    (8),
        .RESET_PC (32'h0),
        .MAX_WAIT (15)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .imem_busy (imem_busy),
        .jump      (jump),
        .branch    (branch),
        .zero      (zero),
        .offset    (offset),
`ifdef PC_SEQ_HALT_EN
        .halt      (halt),
        .resume    (resume),
        .halted    (halted),
`endif
        .pc        (pc),
        .pc_next   (pc_next),
        .imem_req  (imem_req),
        .fault     (fault)
    );

    typedef struct {
        logic        busy;
        logic        jmp;
        logic        br;
        logic        zr;
        logic [7:0]  off;
        logic [31:0] exp_pcn;
        logic [31:0] exp_pc;
        logic        exp_req;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic b, input logic j, input logic br, input logic z, input logic [7:0] o);
        imem_busy = b;
        jump      = j;
        branch    = br;
        zero      = z;
        offset    = o;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd4,  32'd4,  1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd8,  32'd8,  1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hFE, 32'd4,  32'd4,  1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd8,  32'd8,  1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'hFE, 32'd12, 32'd12, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd16, 32'd16, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h03, 32'd32, 32'd32, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hFB, 32'd16, 32'd16, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h03, 32'd32, 32'd32, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h03, 32'd36, 32'd36, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hFB, 32'd20, 32'd20, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h07, 32'd52, 32'd20, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'd24, 32'd20, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'd24, 32'd20, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd24, 32'd24, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'd28, 32'd24, 1'b1};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 32'd32, 32'd32, 1'b1};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hF6, 32'hFFFFFFFC, 32'hFFFFFFFC, 1'b1};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0,  32'd0,  1'b1};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd4,  32'd4,  1'b1};

        // Reset and the dead RST cycle.
        tick();
        chk("rst_pc", pc, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        reset = 1'b0;
        tick();
        chk("run_entry_pc", pc, 32'd0);
        chk("run_entry_req", {31'd0, imem_req}, 32'd1);

        for (int i = 0; i < 20; i++) begin
            set_in(vecs[i].busy, vecs[i].jmp, vecs[i].br, vecs[i].zr, vecs[i].off);
            #1;
            chk($sformatf("vec%0d_pcn", i), pc_next, vecs[i].exp_pcn);
            tick();
            chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
            chk($sformatf("vec%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].exp_req});
            chk($sformatf("vec%0d_fault", i), {31'd0, fault}, 32'd0);
        end

        // Busy for exactly MAX_WAIT cycles, released on the limit cycle: accepted.
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 15; i++) tick();
        chk("limit_pc_held", pc, 32'd4);
        chk("limit_no_fault", {31'd0, fault}, 32'd0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        chk("limit_accept_pc", pc, 32'd8);
        chk("limit_accept_fault", {31'd0, fault}, 32'd0);

        // Busy for MAX_WAIT+1 cycles: fault, frozen until reset.
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 8'h10);
        for (int i = 0; i < 15; i++) tick();
        chk("pre_fault", {31'd0, fault}, 32'd0);
        tick();
        chk("fault_set", {31'd0, fault}, 32'd1);
        chk("fault_req", {31'd0, imem_req}, 32'd0);
        chk("fault_pc", pc, 32'd8);
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 8'h10);
        tick();
        tick();
        chk("fault_sticky", {31'd0, fault}, 32'd1);
        chk("fault_pc_frozen", pc, 32'd8);
        reset = 1'b1;
        tick();
        chk("fault_rst_pc", pc, 32'd0);
        chk("fault_rst_fault", {31'd0, fault}, 32'd0);
        chk("fault_rst_req", {31'd0, imem_req}, 32'd0);
        reset = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();

`ifdef PC_SEQ_HALT_EN
        // Jump to 40, then halt together with a jump: halt wins.
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 8'h09);
        tick();
        chk("halt_pre_pc", pc, 32'd40);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("halted_flag", {31'd0, halted}, 32'd1);
        chk("halted_pc", pc, 32'd40);
        chk("halted_req", {31'd0, imem_req}, 32'd0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        chk("halted_hold", pc, 32'd40);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("resume_pc", pc, 32'd44);
        chk("resume_halted", {31'd0, halted}, 32'd0);
        chk("resume_req", {31'd0, imem_req}, 32'd1);
        tick();
        chk("resume_run_pc", pc, 32'd48);
`endif

        // Reset while in WAIT.
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        tick();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        tick();
        tick();
        chk("wait_req", {31'd0, imem_req}, 32'd1);
        reset = 1'b1;
        tick();
        chk("midwait_rst_pc", pc, 32'd0);
        chk("midwait_rst_req", {31'd0, imem_req}, 32'd0);
        reset = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        chk("midwait_run_pc", pc, 32'd0);
        tick();
        chk("midwait_adv_pc", pc, 32'd4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
